// File: rtl/screen_blitter.sv
// Streams one image from a synchronous image ROM as (x, y, colour) plots, raster order.
// Optional SCREEN_BLIT_TRANSPARENCY_EN: pixels equal to TRANSPARENT_KEY are dropped at FIFO entry.
module screen_blitter #(
  parameter int unsigned H_RES           = 320,
  parameter int unsigned V_RES           = 240,
  parameter int unsigned COLOUR_W        = 3,
  parameter int unsigned NUM_IMG         = 2,
  parameter int unsigned TRANSPARENT_KEY = 0,
  localparam int unsigned X_W = $clog2(H_RES),
  localparam int unsigned Y_W = $clog2(V_RES),
  localparam int unsigned A_W = $clog2(H_RES * V_RES),
  localparam int unsigned S_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [S_W-1:0]      img_sel,
  output logic [A_W-1:0]      rom_addr,
  output logic [S_W-1:0]      rom_sel,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x_pos,
  output logic [Y_W-1:0]      y_pos,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NumPix = H_RES * V_RES;
  localparam int unsigned E_W    = X_W + Y_W + COLOUR_W;

  localparam logic [A_W-1:0] LastAddr = A_W'(NumPix - 1);
  localparam logic [X_W-1:0] LastX    = X_W'(H_RES - 1);
  localparam logic [S_W-1:0] MaxSel   = S_W'(NUM_IMG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [A_W-1:0] addr_q, addr_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [S_W-1:0] sel_q, sel_d;

  // Coordinates of the ROM read currently in flight.
  logic           fl_valid_q;
  logic [X_W-1:0] fl_x_q;
  logic [Y_W-1:0] fl_y_q;

  logic [E_W-1:0] fifo_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     count_q, count_d;

  logic           keep, push, pop, issue;
  logic [2:0]     credit;

`ifdef SCREEN_BLIT_TRANSPARENCY_EN
  assign keep = (rom_data != COLOUR_W'(TRANSPARENT_KEY));
`else
  assign keep = 1'b1;
`endif

  assign plot    = (count_q != 2'd0);
  assign push    = fl_valid_q && keep;
  assign pop     = plot && plot_ready;
  // Slots already claimed once this cycle's pop is accounted for; the skid FIFO holds two.
  assign credit  = {1'b0, count_q} + {2'b00, fl_valid_q} - {2'b00, pop};
  assign issue   = (state_q == StRun) && (credit < 3'd2);
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = (img_sel > MaxSel) ? MaxSel : img_sel;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
            if (x_q == LastX) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      StDrain: begin
        // No issue here, so an empty FIFO after this edge means nothing is left in flight.
        if (count_d == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      fl_valid_q <= 1'b0;
      fl_x_q     <= '0;
      fl_y_q     <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      fl_valid_q <= issue;
      if (issue) begin
        fl_x_q <= x_q;
        fl_y_q <= y_q;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {fl_x_q, fl_y_q, rom_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign {x_pos, y_pos, colour} = fifo_q[rd_ptr_q];
  assign rom_addr = addr_q;
  assign rom_sel  = sel_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: doc/screen_blitter.md
# screen_blitter

Parametrised full-screen image streamer feeding the VGA framebuffer writer. On `start` it reads a selected image from an external synchronous image ROM, one pixel per address in raster order, and presents each pixel as an (x, y, colour) write with a valid/ready handshake. Generalises the fixed two-image 320x240x3 screen display with these additions:
- any resolution, colour depth and image count;
- back-pressure without losing pixels;
- explicit busy and done status.

## Interface
Parameters:
- `H_RES`, 320, pixels per line
- `V_RES`, 240, lines per frame
- `COLOUR_W`, 3, bits per pixel
- `NUM_IMG`, 2, images held in the ROM (≥1)
- `TRANSPARENT_KEY`, 0, colour value treated as transparent (used only with the configuration macro)
- Derived, not overridable:
  - `X_W` = clog2(`H_RES`)
  - `Y_W` = clog2(`V_RES`)
  - `A_W` = clog2(`H_RES`*`V_RES`)
  - `S_W` = max(1, clog2(`NUM_IMG`))

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to blit an image; honoured only in IDLE
- `img_sel`  in  S_W  image index, sampled with `start`
- `rom_addr`  out  A_W  pixel address = y*H_RES + x
- `rom_sel`  out  S_W  latched image index
- `rom_data`  in  COLOUR_W  ROM output, valid exactly 1 cycle after `rom_addr`
- `x_pos`  out  X_W  pixel column
- `y_pos`  out  Y_W  pixel row
- `colour`  out  COLOUR_W  pixel colour
- `plot`  out  1  pixel valid
- `plot_ready`  in  1  downstream accepts the pixel when `plot` && `plot_ready`
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` pulse, inclusive
- `done`  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- FSM states:
  - IDLE:
    - `start` latches `img_sel` into `rom_sel`. If `img_sel` ≥ `NUM_IMG`, it is clamped to `NUM_IMG`-1.
    - Clears the address counter, then moves to RUN.
  - RUN:
    - Issues one address per cycle while credit is available.
    - After issuing address H_RES*V_RES-1, moves to DRAIN.
  - DRAIN:
    - Issues no addresses.
    - When the last pixel is accepted, moves to DONE.
  - DONE:
    - Asserts `done` for one cycle, then returns to IDLE.
- Pixel pipeline:
  - Address counter issues `rom_addr`.
  - A 2-entry output FIFO (skid buffer) holds {x, y, colour}.
  - The head entry drives the outputs. `plot` = FIFO not empty.
- Credit rule: an address is issued in a cycle only if (FIFO occupancy + in-flight ROM reads − pop this cycle) < 2. This guarantees no overflow.
- x/y tracking:
  - x and y travel alongside the in-flight read.
  - x wraps from H_RES-1 to 0 with y+1.
  - The last pixel is (H_RES-1, V_RES-1).
  - Counters never exceed their range.
- `start` while `busy` is ignored; it has no effect on `rom_sel` or progress.
- `plot_ready` low holds the outputs stable; no pixel is dropped or duplicated.
- `reset` (any state, mid-frame included) returns the block to IDLE, empties the FIFO and cancels the in-flight read. The next `start` begins again at pixel 0.
- Reset values:
  - `x_pos`=0, `y_pos`=0, `colour`=0
  - `plot`=0, `busy`=0, `done`=0
  - `rom_addr`=0, `rom_sel`=0

## Timing
- Edge e0 samples `start`.
- `rom_addr`=0 is driven after e0.
- `rom_data` is valid after e1.
- The pixel is registered into the FIFO at e2, so `plot` is first high after e2.
- Latency from `start` to first `plot` is 2 cycles.
- With `plot_ready` held high, throughput is 1 pixel/cycle: H_RES*V_RES consecutive `plot` cycles.
- `done` goes high the cycle after the last handshake.
- Total time from `start` to `done` is H_RES*V_RES+2 cycles (76802 at defaults).
- When `plot_ready` drops, the FIFO absorbs the read already in flight; the issue stalls within one cycle.
- On release of back-pressure, `plot` stays continuous with no bubble.

## Configuration
- `SCREEN_BLIT_TRANSPARENCY_EN`:
  - Defined: pixels whose colour equals `TRANSPARENT_KEY` are discarded at FIFO entry. `plot` is never asserted for them, but x/y still advance. `done` timing counts only the last non-transparent acceptance, or the last ROM return if that is later.
  - Undefined: every pixel is plotted and `TRANSPARENT_KEY` is unused.

## Test plan
- Defaults, ROM pixel = addr[2:0], `plot_ready`=1, `start` with `img_sel`=1:
  - `rom_sel`=1.
  - 76800 plots; first is (0,0,0); pixel 321 is (1,1,1); last is (319,239,7).
  - `done` at cycle 76802 after `start`.
- Random `plot_ready` (50%) → same 76800-pixel sequence, no drops or duplicates; `busy` high throughout; exactly one `done` pulse.
- H_RES=4, V_RES=3, `plot_ready` low for 5 cycles after the first plot → outputs frozen at (0,0); at most 2 addresses issued; the remaining 12-pixel sequence is intact.
- `start` with `img_sel`=1 pulsed again mid-frame → ignored; `rom_sel` is unchanged and the frame completes normally.
- `reset` asserted at pixel 100 → all outputs return to their reset values immediately; the next `start` restarts at (0,0).
- With `SCREEN_BLIT_TRANSPARENCY_EN`, `TRANSPARENT_KEY`=0, ROM = addr[2:0] → 67200 plots, none with colour 0.
